dff_bank_arbiter: RTL
=====================

Name: dff_bank_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit D-flip-flop register (the shared storage bank) between N requesters. Each cycle it samples the requests, picks a winner, drives the register's enable and data, and reports the grant. It supports a lock for multi-cycle ownership. It sits between requester blocks and the shared D-flip-flop register.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, data width of the shared register
IDW, 2, width of grant_id; must equal clog2(N)
MAX_HOLD, 4, maximum consecutive locked cycles per owner (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request vector, bit i = requester i
lock  input  N  bit i high = requester i wants to keep its grant next cycle
wdata  input  N*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH]
grant  output  N  one-hot grant, registered
grant_valid  output  1  OR of grant, registered
grant_id  output  IDW  index of the granted requester; 0 when none
reg_we  output  1  write enable to the shared D register, registered
reg_d  output  WIDTH  data for the shared D register, registered
reg_q  output  WIDTH  contents of the shared D register

Behaviour:
- Reset values: grant, grant_valid, grant_id, reg_we and reg_d are 0. reg_q is 0. The round-robin pointer ptr is 0, so requester 0 has highest priority. The FSM state is IDLE.
- All outputs are registered. Requests sampled at edge k produce grant and reg_we/reg_d valid during cycle k+1.
- reg_q loads reg_d at the edge that ends a cycle with reg_we=1. Total latency from req to reg_q is 2 edges.
- FSM:
  - IDLE: no grant.
  - GRANT: single-cycle ownership.
  - LOCKED: ownership kept because of lock.
- Winner selection (IDLE or GRANT): the first requester with req=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - If any req is set: go to GRANT, or to LOCKED when lock[winner]=1.
  - If none: go to IDLE.
- On granting w, ptr updates to (w+1) mod N, wrapping from N-1 to 0.
- LOCKED, owner o:
  - If req[o]=1 and lock[o]=1: keep the grant and do not move ptr. Other requesters wait.
  - If req[o]=0 or lock[o]=0: re-arbitrate that same edge exactly as in IDLE/GRANT.
- reg_we=1 exactly when grant_valid=1.
- reg_d is the wdata slice of the requester being granted, captured at the same edge as the grant.
- No requests: grant=0 and reg_we=0; reg_q holds its value.
- Simultaneous requests: exactly one grant per cycle. The grant is always one-hot or zero.
- A requester whose req drops while it is granted loses the grant at the next edge. The write already issued for that cycle still completes.
- Reset mid-operation clears all state in the same edge, including a lock in progress and reg_q. Reset has priority over every other event.

Optional Feature:
Macro ARB_HOLD_LIMIT_EN.
- Defined: a hold counter (width clog2(MAX_HOLD+1)) counts consecutive cycles in LOCKED for the current owner. When it reaches MAX_HOLD, the next edge forces re-arbitration with the owner excluded for that one decision. If the owner is the only requester, it is re-granted and the counter restarts. The counter clears on reset and on every new owner.
- Undefined: no counter; a lock may be held indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding localparams IDLE=2'd0, GRANT=2'd1, LOCKED=2'd2;
  - the default WIDTH/N constants.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: one-hot winner, winner index, any-valid.
- The arbiter instantiates rr_pick once. reg_q is a plain WIDTH-bit D register inside the top module.

Test Plan:
1. Reset: assert reset for 2 cycles with req=4'b1111 -> grant=0, reg_we=0, reg_q=0 throughout. After release with req=4'b1111, the first grant is 4'b0001 (id 0).
2. Round-robin rotation: req=4'b1111 held, lock=0, wdata slices 0x11/0x22/0x33/0x44 -> grant sequence 0001, 0010, 0100, 1000, 0001. The reg_q sequence lags reg_d by one cycle: 0x11, 0x22, 0x33, 0x44.
3. Wrap and sparse requests: ptr=3 (after a grant to requester 2), req=4'b0011 -> grant to requester 0, ptr becomes 1. Next cycle with the same req -> grant to requester 1.
4. Lock: requester 2 holds req and lock for 6 cycles while req[0]=1 -> grant=0100 for all 6 cycles. After lock drops -> grant=0001.
   - With ARB_HOLD_LIMIT_EN and MAX_HOLD=4: requester 0 is granted after 4 locked cycles instead.
5. Request drop mid-lock: requester 1 locked, req[1] falls at cycle k -> grant_valid=0 in cycle k+1 if no other requests. reg_q keeps the last value written.
6. Reset mid-lock: assert reset while LOCKED with reg_q=0xA5 -> next cycle grant=0, reg_q=0, ptr=0, and the FSM is in IDLE.

Source files
------------

// File: rtl/dff_bank_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter_pkg
// Shared constants for the DFF bank arbiter slice: default requester count and
// data width, plus the FSM state encoding used by dff_bank_arbiter.
// -----------------------------------------------------------------------------
package dff_bank_arbiter_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = IDLE,
        S_GRANT  = GRANT,
        S_LOCKED = LOCKED
    } arb_state_t;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches the eligible requests
// (req with excl masked off) starting at ptr and wrapping through N-1 to 0.
// Ports:
//   req    [N-1:0]   request vector
//   ptr    [IDW-1:0] highest-priority index for this decision
//   excl   [N-1:0]   requesters that may not win this decision
//   winner [N-1:0]   one-hot winner (zero when none)
//   idx    [IDW-1:0] winner index (zero when none)
//   any              at least one eligible requester
// -----------------------------------------------------------------------------
module rr_pick
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   excl,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   winner,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0] elig_s;

    assign elig_s = req & ~excl;

    // Rotating first-one search starting at ptr.
    always_comb begin
        winner = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            int cand;
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!any && elig_s[cand]) begin
                any          = 1'b1;
                winner[cand] = 1'b1;
                idx          = IDW'(cand);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// -----------------------------------------------------------------------------
// dff_bank_arbiter
// Round-robin arbiter sharing one WIDTH-bit D register between N requesters,
// with lock support for multi-cycle ownership. All outputs are registered;
// reg_q is the shared register itself and loads reg_d when reg_we is high.
// Optional feature: define ARB_HOLD_LIMIT_EN to cap a locked ownership at
// MAX_HOLD consecutive cycles, after which the owner is skipped for one
// decision (re-granted if it is the only requester).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req, lock   [N-1:0]   requests and lock (keep grant) requests
//   wdata   [N*WIDTH-1:0] per-requester write data, slice i at [i*WIDTH +: WIDTH]
//   grant       [N-1:0]   one-hot grant
//   grant_valid           OR of grant
//   grant_id  [IDW-1:0]   index of granted requester, 0 when none
//   reg_we                write enable to the shared register
//   reg_d   [WIDTH-1:0]   data to the shared register
//   reg_q   [WIDTH-1:0]   shared register contents
// -----------------------------------------------------------------------------
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [IDW-1:0]       grant_id,
    output logic                 reg_we,
    output logic [WIDTH-1:0]     reg_d,
    output logic [WIDTH-1:0]     reg_q
);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    ptr_nxt_s;
    logic [N-1:0]      grant_r;
    logic [N-1:0]      grant_nxt_s;
    logic [IDW-1:0]    grant_id_r;
    logic [IDW-1:0]    id_nxt_s;
    logic              grant_valid_r;
    logic              reg_we_r;
    logic [WIDTH-1:0]  reg_d_r;
    logic [WIDTH-1:0]  d_nxt_s;
    logic [WIDTH-1:0]  reg_q_r;

    logic [N-1:0]      pick_oh_s;
    logic [IDW-1:0]    pick_idx_s;
    logic              pick_any_s;
    logic [N-1:0]      excl_s;
    logic              keep_raw_s;
    logic              keep_s;

    // While LOCKED, grant_r is the owner's one-hot and grant_id_r its index.
    assign keep_raw_s = (state_r == S_LOCKED) && req[grant_id_r] && lock[grant_id_r];

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HCW = $clog2(MAX_HOLD + 1);

    logic [HCW-1:0] hold_cnt_r;
    logic [HCW-1:0] hold_nxt_s;
    logic           limit_s;

    // hold_cnt_r counts locked cycles of the current owner including this one.
    assign limit_s = keep_raw_s && (hold_cnt_r == HCW'(MAX_HOLD));
    assign keep_s  = keep_raw_s && !limit_s;
    // Skip the owner only when someone else can take over; otherwise re-grant it.
    assign excl_s  = (limit_s && ((req & ~grant_r) != '0)) ? grant_r : '0;

    // Hold counter next value: bump on keep, restart on a fresh locked grant.
    always_comb begin
        hold_nxt_s = '0;
        if (keep_s) begin
            hold_nxt_s = hold_cnt_r + HCW'(1);
        end else if (pick_any_s && lock[pick_idx_s]) begin
            hold_nxt_s = HCW'(1);
        end else begin
            hold_nxt_s = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_r <= '0;
        end else begin
            hold_cnt_r <= hold_nxt_s;
        end
    end
`else
    assign keep_s = keep_raw_s;
    assign excl_s = '0;
`endif

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .excl   (excl_s),
        .ptr    (ptr_r),
        .winner (pick_oh_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Next-state decision: keep a locked owner, else arbitrate, else go idle.
    always_comb begin
        state_nxt_s = S_IDLE;
        grant_nxt_s = '0;
        id_nxt_s    = '0;
        ptr_nxt_s   = ptr_r;
        d_nxt_s     = '0;
        if (keep_s) begin
            state_nxt_s = S_LOCKED;
            grant_nxt_s = grant_r;
            id_nxt_s    = grant_id_r;
            d_nxt_s     = wdata[int'(grant_id_r)*WIDTH +: WIDTH];
        end else if (pick_any_s) begin
            state_nxt_s = lock[pick_idx_s] ? S_LOCKED : S_GRANT;
            grant_nxt_s = pick_oh_s;
            id_nxt_s    = pick_idx_s;
            ptr_nxt_s   = (pick_idx_s == IDW'(N - 1)) ? '0 : pick_idx_s + IDW'(1);
            d_nxt_s     = wdata[int'(pick_idx_s)*WIDTH +: WIDTH];
        end else begin
            state_nxt_s = S_IDLE;
            grant_nxt_s = '0;
            id_nxt_s    = '0;
            ptr_nxt_s   = ptr_r;
            d_nxt_s     = '0;
        end
    end

    // FSM and registered outputs; write enable follows the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            ptr_r         <= '0;
            grant_r       <= '0;
            grant_id_r    <= '0;
            grant_valid_r <= 1'b0;
            reg_we_r      <= 1'b0;
            reg_d_r       <= '0;
        end else begin
            state_r       <= state_nxt_s;
            ptr_r         <= ptr_nxt_s;
            grant_r       <= grant_nxt_s;
            grant_id_r    <= id_nxt_s;
            grant_valid_r <= |grant_nxt_s;
            reg_we_r      <= |grant_nxt_s;
            reg_d_r       <= d_nxt_s;
        end
    end

    // Shared D register: loads the data issued during a write-enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_q_r <= '0;
        end else if (reg_we_r) begin
            reg_q_r <= reg_d_r;
        end else begin
            reg_q_r <= reg_q_r;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;
    assign reg_we      = reg_we_r;
    assign reg_d       = reg_d_r;
    assign reg_q       = reg_q_r;

endmodule
